// File: rtl/logic_issue_stage_pkg.sv
// Shared definitions for the logical-unit issue stage.
// Holds the FLAG encodings, the MIPS opcode/funct constants and the issue-entry layout.
package logic_issue_stage_pkg;

    localparam int ISSUE_DATA_W = 32;
    localparam int ISSUE_REG_W  = 5;

    // FLAG codes understood by the downstream logical unit
    localparam logic [3:0] LOGIC_AND  = 4'b1000;
    localparam logic [3:0] LOGIC_OR   = 4'b1110;
    localparam logic [3:0] LOGIC_XOR  = 4'b0110;
    localparam logic [3:0] LOGIC_NOR  = 4'b0001;
    localparam logic [3:0] LOGIC_A    = 4'b1010;
    localparam logic [3:0] LOGIC_NONE = 4'b0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    typedef struct packed {
        logic [ISSUE_DATA_W-1:0] a;
        logic [ISSUE_DATA_W-1:0] b;
        logic [3:0]              flag;
        logic [ISSUE_REG_W-1:0]  rd;
        logic                    illegal;
    } issue_entry_t;

    function automatic logic [ISSUE_DATA_W-1:0] zext_imm(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/logic_issue_stage_decode.sv
// Combinational decode of a MIPS logical instruction into an issue entry.
// Non-logical instructions still produce an entry, marked illegal with FLAG 0000.
module logic_decode
    import logic_issue_stage_pkg::*;
(
    input  logic [5:0]              opcode,
    input  logic [5:0]              funct,
    input  logic [ISSUE_DATA_W-1:0] rs_val,
    input  logic [ISSUE_DATA_W-1:0] rt_val,
    input  logic [15:0]             imm,
    input  logic [ISSUE_REG_W-1:0]  rd,
    output issue_entry_t            entry
);

    always_comb begin
        entry.a       = rs_val;
        entry.b       = rt_val;
        entry.flag    = LOGIC_NONE;
        entry.rd      = rd;
        entry.illegal = 1'b1;

        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_AND: begin entry.flag = LOGIC_AND; entry.illegal = 1'b0; end
                    FN_OR:  begin entry.flag = LOGIC_OR;  entry.illegal = 1'b0; end
                    FN_XOR: begin entry.flag = LOGIC_XOR; entry.illegal = 1'b0; end
                    FN_NOR: begin entry.flag = LOGIC_NOR; entry.illegal = 1'b0; end
                    default: ;
                endcase
            end
            OP_ANDI: begin
                entry.b       = zext_imm(imm);
                entry.flag    = LOGIC_AND;
                entry.illegal = 1'b0;
            end
            OP_ORI: begin
                entry.b       = zext_imm(imm);
                entry.flag    = LOGIC_OR;
                entry.illegal = 1'b0;
            end
            OP_XORI: begin
                entry.b       = zext_imm(imm);
                entry.flag    = LOGIC_XOR;
                entry.illegal = 1'b0;
            end
            // LUI is executed as "pass A" with the immediate pre-shifted into the upper half
            OP_LUI: begin
                entry.a       = {imm, 16'h0000};
                entry.b       = '0;
                entry.flag    = LOGIC_A;
                entry.illegal = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/logic_issue_stage.sv
// Issue stage feeding the ALU logical unit: decode, registered output plus one skid entry.
// in_ready depends only on skid occupancy, so it never combinationally follows out_ready.
module logic_issue_stage
    import logic_issue_stage_pkg::*;
#(
    parameter int DATA_W = ISSUE_DATA_W,
    parameter int REG_W  = ISSUE_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [15:0]       in_imm,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [3:0]        out_flag,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_illegal
);

    issue_entry_t dec_entry;
    issue_entry_t main_reg, main_next;
    issue_entry_t skid_reg, skid_next;
    logic         main_valid_reg, main_valid_next;
    logic         skid_valid_reg, skid_valid_next;
    logic         in_xfer;
    logic         main_free;

    logic_decode u_decode (
        .opcode (in_opcode),
        .funct  (in_funct),
        .rs_val (in_rs_val),
        .rt_val (in_rt_val),
        .imm    (in_imm),
        .rd     (in_rd),
        .entry  (dec_entry)
    );

    assign in_ready  = ~skid_valid_reg;
    assign in_xfer   = in_valid & in_ready;
    // Main can take new data when empty or when its current content leaves this cycle
    assign main_free = ~main_valid_reg | out_ready;

    always_comb begin
        main_next       = main_reg;
        main_valid_next = main_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;

        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (main_free) begin
            // Skid holds the older entry, so it always wins over a same-cycle input
            if (skid_valid_reg) begin
                main_next       = skid_reg;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end else begin
                main_valid_next = in_xfer;
                if (in_xfer) begin
                    main_next = dec_entry;
                end
            end
        end else if (in_xfer) begin
            skid_next       = dec_entry;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    assign out_valid   = main_valid_reg;
    assign out_a       = main_reg.a;
    assign out_b       = main_reg.b;
    assign out_flag    = main_reg.flag;
    assign out_rd      = main_reg.rd;
    assign out_illegal = main_reg.illegal;

endmodule

// File: doc/logic_issue_stage.md
Name: logic_issue_stage

Overview:
- Issue/decode stage directly upstream of the ALU logical unit.
- Accepts decoded MIPS logical instructions (AND/OR/XOR/NOR, ANDI/ORI/XORI, LUI) over a valid/ready handshake.
- Forms the A/B operands and the 4-bit logic FLAG code, and presents them registered to the logical unit.
- Two-entry skid buffer gives full throughput under downstream backpressure; a synchronous flush squashes in-flight work on branch/exception.

Parameters:
- DATA_W, 32, operand width (A, B).
- REG_W, 5, destination register index width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_opcode  in  6  MIPS opcode field.
- in_funct  in  6  MIPS funct field (used when opcode==0).
- in_rs_val  in  DATA_W  rs register value.
- in_rt_val  in  DATA_W  rt register value.
- in_imm  in  16  immediate field.
- in_rd  in  REG_W  destination index, already resolved upstream.
- out_valid  out  1  operands/flag valid to logical unit.
- out_ready  in  1  downstream accepts.
- out_a  out  DATA_W  operand A.
- out_b  out  DATA_W  operand B.
- out_flag  out  4  logic function code.
- out_rd  out  REG_W  destination index.
- out_illegal  out  1  instruction not a logical op; flag forced to 0000.

Behaviour:
- Reset (rst_n=0, async): out_valid=0; out_a, out_b, out_rd=0; out_flag=0000; out_illegal=0; skid entry empty; in_ready=1.
- Decode (combinational, on input side):
  - opcode 0x00, funct 0x24 -> flag 1000 (AND), A=rs, B=rt.
  - funct 0x25 -> 1110 (OR). funct 0x26 -> 0110 (XOR). funct 0x27 -> 0001 (NOR).
  - opcode 0x0C/0x0D/0x0E -> 1000/1110/0110; A=rs, B={16'h0, imm} (zero-extend).
  - opcode 0x0F (LUI) -> 1010 (pass A); A={imm, 16'h0}, B=0.
  - Anything else -> flag 0000, A=rs, B=rt, illegal=1. Still issued, never dropped.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Storage: output register (main) plus one skid register.
- in_ready = ~skid_valid. It is registered state, not combinationally dependent on out_ready.
- Latency: 1 cycle from input transfer to out_valid when main is empty or draining.
- Main register loads:
  - If main is empty or an output transfer occurs: load from skid if skid_valid, else from the input transfer.
  - Else, an input transfer goes to skid.
- Ordering: strict FIFO. Skid is always older than a same-cycle input.
- Simultaneous output transfer + input transfer with skid empty: main reloads from input; out_valid stays 1.
- Output stable rule: while out_valid & ~out_ready, out_* must not change.
- Flush:
  - Next edge: out_valid=0, skid emptied, in_ready=1.
  - Flush beats a same-cycle input transfer (the input is discarded).
  - Data registers may hold stale values; verify only on valid.
- Reset mid-transfer: all entries lost immediately; no output transfer is reported.
- No counters wrap. Widths are fixed; LUI shift is a concatenation, not arithmetic.

Decomposition:
- Shared package holds:
  - Flag constants: LOGIC_AND=1000, LOGIC_OR=1110, LOGIC_XOR=0110, LOGIC_NOR=0001, LOGIC_A=1010, LOGIC_NONE=0000.
  - Opcode/funct constants.
  - A packed issue-entry typedef {a, b, flag, rd, illegal}.
- One sub-module is natural: logic_decode (pure combinational opcode/funct/imm -> entry). The top holds the main and skid registers and the handshake.

Test Plan:
- Reset release, then AND: rs=F0F0_F0F0, rt=FF00_FF00, rd=3, out_ready=1 -> next cycle out_valid=1, flag=1000, a=F0F0_F0F0, b=FF00_FF00, rd=3, illegal=0.
- ORI then LUI back-to-back, imm=0x1234 -> ORI: b=0000_1234, flag=1110. Next cycle LUI: a=1234_0000, b=0, flag=1010.
- Backpressure: out_ready=0, push 2 ops (XOR, NOR) -> in_ready=0 after the second. Raise out_ready -> XOR out then NOR out on consecutive cycles, in order, outputs stable while stalled.
- Illegal: opcode=0x23 (LW) -> out_valid=1, flag=0000, illegal=1, a=rs, b=rt.
- Flush with both entries full plus in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1; no squashed op ever appears.
- Async reset asserted mid-cycle with out_valid=1 -> out_valid=0 immediately without a clock edge; in_ready=1.
